// File: rtl/hilo_mdu_ctrl.sv
// hilo_mdu_ctrl: HI/LO multiply/divide unit controller for the EX stage.
//
// Accepts MULT/MULTU (5 busy cycles), DIV/DIVU (10 busy cycles) and
// MTHI/MTLO (single-edge write, never busy). HI/LO are written only on the
// completion edge of a multi-cycle op or on the accepting edge of MTHI/MTLO.
//
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous active-low reset
//   start   HI/LO-class instruction valid in EX
//   op      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//   rs_val  rs operand (multiplicand / dividend / MT source)
//   rt_val  rt operand (multiplier / divisor)
//   flush   EX instruction squashed
//   hl_rd   EX instruction is MFHI/MFLO
//   hl_sel  0 = LO, 1 = HI on hl_out
//   busy    multi-cycle operation in flight
//   stall   freeze IF/ID/EX, bubble EX_MEM
//   hl_out  selected HI or LO value
module hilo_mdu_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  input  logic        hl_rd,
  input  logic        hl_sel,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hl_out
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMul  = 2'd1;
  localparam logic [1:0] StDiv  = 2'd2;

  // Counter load values: done fires when the counter is already zero, so a
  // load of N-1 gives N busy cycles after the accepting edge.
  localparam logic [3:0] MulCnt = 4'd4;
  localparam logic [3:0] DivCnt = 4'd9;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        signed_q, signed_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  // Goes high on the first edge after reset release; blocks accept on that edge.
  logic        rdy_q;

  logic        op_valid;
  logic        accept;

  assign busy     = (state_q != StIdle);
  assign stall    = busy & (start | hl_rd);
  assign hl_out   = hl_sel ? hi_q : lo_q;
  assign op_valid = (op[2:1] != 2'b11);
  assign accept   = start & ~flush & ~busy & op_valid & rdy_q;

  // Multiply: sign- or zero-extend to 64 bits; the low 64 bits of the
  // product are exact for both signed and unsigned operands.
  logic [63:0] mul_a, mul_b, product;
  always_comb begin
    mul_a   = signed_q ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
    mul_b   = signed_q ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
    product = mul_a * mul_b;
  end

  // Divide on magnitudes, then restore signs: quotient truncates toward zero,
  // remainder follows the dividend. 0x80000000 / -1 falls out naturally.
  logic        a_neg, b_neg, b_zero;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;
  always_comb begin
    a_neg  = signed_q & a_q[31];
    b_neg  = signed_q & b_q[31];
    a_mag  = a_neg ? (~a_q + 32'd1) : a_q;
    b_mag  = b_neg ? (~b_q + 32'd1) : b_q;
    b_zero = (b_q == 32'd0);
    q_mag  = 32'd0;
    r_mag  = 32'd0;
    if (!b_zero) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end
    quot = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    rem  = a_neg ? (~r_mag + 32'd1) : r_mag;
    if (b_zero) begin
      quot = 32'hFFFF_FFFF;
      rem  = a_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    signed_d = signed_q;
    a_d      = a_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          signed_d = ~op[0];
          a_d      = rs_val;
          b_d      = rt_val;
          case (op)
            3'b000, 3'b001: begin
              state_d = StMul;
              cnt_d   = MulCnt;
            end
            3'b010, 3'b011: begin
              state_d = StDiv;
              cnt_d   = DivCnt;
            end
            3'b100:  hi_d = rs_val;
            3'b101:  lo_d = rs_val;
            default: ;
          endcase
        end
      end
      StMul: begin
        if (cnt_q == 4'd0) begin
          hi_d    = product[63:32];
          lo_d    = product[31:0];
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDiv: begin
        if (cnt_q == 4'd0) begin
          hi_d    = rem;
          lo_d    = quot;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      signed_q <= 1'b0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      signed_q <= signed_d;
      a_q      <= a_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      rdy_q    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
module tb_hilo_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        flush;
  logic        hl_rd;
  logic        hl_sel;
  logic        busy;
  logic        stall;
  logic [31:0] hl_out;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  hilo_mdu_ctrl dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .flush  (flush),
    .hl_rd  (hl_rd),
    .hl_sel (hl_sel),
    .busy   (busy),
    .stall  (stall),
    .hl_out (hl_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
    hl_sel = 1'b1; #1;
    check({tag, "_hi"}, hl_out, hi);
    hl_sel = 1'b0; #1;
    check({tag, "_lo"}, hl_out, lo);
  endtask

  // Present one op for a single accepting edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    step();
    start = 1'b0;
  endtask

  // Expect busy high for exactly n cycles after the accepting edge.
  task automatic busy_for(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      check({tag, "_busy"}, {31'b0, busy}, 32'd1);
      step();
    end
    check({tag, "_done"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op = 3'b000; rs_val = 32'd0; rt_val = 32'd0;
    flush = 1'b0; hl_rd = 1'b0; hl_sel = 1'b0;
    #2;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_stall", {31'b0, stall}, 32'd0);
    chk_hilo("rst", 32'd0, 32'd0);
    step(); step();
    reset = 1'b1;
    step(); step();

    // MULT signed: -1 * 2
    issue(3'b000, 32'hFFFF_FFFF, 32'd2);
    busy_for("mult", 5);
    chk_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE);

    // MULTU with MFHI held during busy
    hl_rd = 1'b1; hl_sel = 1'b1;
    start = 1'b1; op = 3'b001; rs_val = 32'hFFFF_FFFF; rt_val = 32'd2; #1;
    check("idle_stall", {31'b0, stall}, 32'd0);
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("multu_stall", {31'b0, stall}, 32'd1);
      step();
    end
    check("multu_stall_end", {31'b0, stall}, 32'd0);
    check("multu_mfhi", hl_out, 32'd1);
    hl_rd = 1'b0;
    chk_hilo("multu", 32'd1, 32'hFFFF_FFFE);

    // MULT min*min
    issue(3'b000, 32'h8000_0000, 32'h8000_0000);
    busy_for("mult_min", 5);
    chk_hilo("mult_min", 32'h4000_0000, 32'd0);

    // DIV -7 / 2
    issue(3'b010, 32'hFFFF_FFF9, 32'd2);
    busy_for("div", 10);
    chk_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    // DIVU 100 / 0
    issue(3'b011, 32'd100, 32'd0);
    busy_for("divu0", 10);
    chk_hilo("divu0", 32'h64, 32'hFFFF_FFFF);

    // DIV overflow
    issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
    busy_for("div_ovf", 10);
    chk_hilo("div_ovf", 32'd0, 32'h8000_0000);

    // DIVU 0x80000000 / 0xFFFFFFFF
    issue(3'b011, 32'h8000_0000, 32'hFFFF_FFFF);
    busy_for("divu_big", 10);
    chk_hilo("divu_big", 32'h8000_0000, 32'd0);

    // MTLO flushed, then accepted
    flush = 1'b1;
    issue(3'b101, 32'h1234, 32'd0);
    flush = 1'b0;
    check("mtlo_flush_busy", {31'b0, busy}, 32'd0);
    chk_hilo("mtlo_flush", 32'h8000_0000, 32'd0);
    issue(3'b101, 32'h1234, 32'd0);
    check("mtlo_busy", {31'b0, busy}, 32'd0);
    chk_hilo("mtlo", 32'h8000_0000, 32'h1234);

    // MTHI, then reserved op leaves everything alone
    issue(3'b100, 32'hABCD, 32'd0);
    check("mthi_busy", {31'b0, busy}, 32'd0);
    issue(3'b110, 32'h5555, 32'h7);
    check("rsvd_busy", {31'b0, busy}, 32'd0);
    chk_hilo("rsvd", 32'hABCD, 32'h1234);

    // Reset mid-DIV
    issue(3'b010, 32'd50, 32'd5);
    step(); step(); step();
    check("div_inflight", {31'b0, busy}, 32'd1);
    reset = 1'b0; #1;
    check("abort_busy", {31'b0, busy}, 32'd0);
    chk_hilo("abort", 32'd0, 32'd0);
    step();
    // Release with MULT already presented: releasing edge must not accept.
    #2;
    reset = 1'b1; start = 1'b1; op = 3'b000; rs_val = 32'd3; rt_val = 32'd4;
    step();
    check("release_no_accept", {31'b0, busy}, 32'd0);
    step();
    start = 1'b0;
    busy_for("mult_after_rst", 5);
    chk_hilo("mult_after_rst", 32'd0, 32'd12);

    // MULT, then DIV held during busy (with a flush pulse that must be ignored)
    issue(3'b000, 32'd6, 32'd7);
    start = 1'b1; op = 3'b010; rs_val = 32'd100; rt_val = 32'd7;
    for (int i = 0; i < 5; i++) begin
      flush = (i == 1);
      #1;
      check("held_stall", {31'b0, stall}, 32'd1);
      step();
    end
    flush = 1'b0;
    check("held_busy_fell", {31'b0, busy}, 32'd0);
    check("held_stall_fell", {31'b0, stall}, 32'd0);
    chk_hilo("held_mult", 32'd0, 32'd42);
    step();
    start = 1'b0;
    busy_for("held_div", 10);
    chk_hilo("held_div", 32'd2, 32'd14);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hilo_mdu_ctrl.md
HILO_MDU_CTRL -- requirements
Module: hilo_mdu_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 clk  in  1  rising-edge clock shared with pipeline registers.
REQ-003 reset  in  1  asynchronous, active-low; 0 forces reset state immediately.
REQ-004 start  in  1  EX-stage HI/LO-class instruction valid this cycle.
REQ-005 op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x reserved.
REQ-006 rs_val  in  32  forwarded rs operand (multiplicand/dividend/MT source).
REQ-007 rt_val  in  32  forwarded rt operand (multiplier/divisor).
REQ-008 flush  in  1  EX instruction squashed this cycle.
REQ-009 hl_rd  in  1  EX instruction is MFHI/MFLO.
REQ-010 hl_sel  in  1  0 selects LO, 1 selects HI for hl_out.
REQ-011 busy  out  1  multi-cycle operation in progress.
REQ-012 stall  out  1  freeze IF/ID/EX and bubble EX_MEM this cycle.
REQ-013 hl_out  out  32  HI or LO per hl_sel, feeds the EX-to-MEM HL path.

Function
REQ-014 States SHALL be IDLE, MUL, DIV; a 4-bit down-counter SHALL sequence MUL and DIV.
REQ-015 Accept = start & ~flush & ~busy & op valid; accepted ops SHALL latch op and operands at the accepting edge.
REQ-016 Accepted MULT/MULTU SHALL enter MUL with busy=1 for exactly 5 cycles after the accepting edge; HI/LO SHALL update on the 5th edge, the same edge busy falls.
REQ-017 Accepted DIV/DIVU SHALL enter DIV with busy=1 for exactly 10 cycles; HI/LO SHALL update on the 10th edge, the same edge busy falls.
REQ-018 MULT/MULTU SHALL write the signed/unsigned 64-bit product, HI=[63:32], LO=[31:0].
REQ-019 DIV/DIVU SHALL write LO=quotient, HI=remainder; signed quotient truncates toward zero; remainder takes the dividend's sign.
REQ-020 Divisor zero SHALL give LO=0xFFFFFFFF, HI=rs_val; DIV 0x80000000/0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-021 Accepted MTHI/MTLO SHALL write rs_val to HI/LO at the accepting edge with no busy.
REQ-022 Reserved op or flushed start SHALL leave state, HI and LO unchanged.
REQ-023 stall SHALL be combinational: busy & (start | hl_rd); stall SHALL be 0 in IDLE.
REQ-024 start while busy SHALL not be accepted; the held instruction is re-presented and SHALL be accepted on the first cycle busy=0.
REQ-025 flush while busy SHALL be ignored; the in-flight operation SHALL complete.
REQ-026 hl_out SHALL be combinational from registered HI/LO; a read in the cycle after completion SHALL return new values.
REQ-027 Intermediate iteration state SHALL never be visible on hl_out; HI/LO SHALL change only at the REQ-016/017/021 edges.
REQ-028 Internal arithmetic SHALL use 64-bit product and 33-bit partial-remainder widths with no truncation before the final write.

Reset
REQ-029 reset=0 SHALL immediately force IDLE, counter=0, busy=0, HI=0, LO=0, hl_out=0 and stall=0.
REQ-030 Reset mid-MUL/DIV SHALL abort with no HI/LO write; the first accept after release SHALL behave as from power-up.
REQ-031 Reset release SHALL be synchronized to clk; no accept SHALL occur on the releasing edge.

Verification
REQ-032 MULT rs=0xFFFFFFFF rt=2 -> busy 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
REQ-033 MULTU rs=0xFFFFFFFF rt=2 -> HI=0x00000001, LO=0xFFFFFFFE; MFHI held during busy -> stall=1 for 5 cycles, then reads 1.
REQ-034 DIV rs=0xFFFFFFF9 (-7) rt=2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100/0 -> LO=0xFFFFFFFF, HI=0x64.
REQ-035 MTLO 0x1234 with flush=1 -> LO unchanged; repeated with flush=0 -> LO=0x1234 next cycle, busy never 1.
REQ-036 DIV accepted, reset=0 at cycle 4 -> busy=0, HI=LO=0 immediately; after release, MULT 3*4 -> LO=12, HI=0.
REQ-037 MULT accepted, DIV start held during busy -> stall=1 for 5 cycles; DIV accepted on the cycle busy falls; then busy=1 for 10 cycles.
